// File: rtl/aes_kat_sequencer.sv
// Known-answer-test sequencer for an external AES-128 core: replays the SP800-38A ECB vectors
// and scores each ciphertext. Define AES_KAT_TIMEOUT_EN to build the WAIT-state watchdog.
module aes_kat_sequencer #(
  parameter int NUM_VEC        = 4,
  parameter int GAP_CYCLES     = 100,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             loop,
  output logic             aes_ld,
  output logic [127:0]     aes_key,
  output logic [127:0]     aes_text_in,
  input  logic             aes_done,
  input  logic [127:0]     aes_text_out,
  output logic             busy,
  output logic [1:0]       vec_idx,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             error,
  output logic             pass_ok,
  output logic             timeout
);

  localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  // One down-counter serves both the GAP delay and the WAIT watchdog, so it is sized for the larger.
  localparam int               TMR_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int               TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LD   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       LAST    = 2'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GAP   = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4
  } state_t;

  function automatic logic [127:0] kat_pt(input logic [1:0] i);
    case (i)
      2'd0:    kat_pt = 128'h6bc1bee22e409f96e93d7e117393172a;
      2'd1:    kat_pt = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      2'd2:    kat_pt = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
      default: kat_pt = 128'hf69f2445df4f9b17ad2b417be66c3710;
    endcase
  endfunction

  function automatic logic [127:0] kat_ct(input logic [1:0] i);
    case (i)
      2'd0:    kat_ct = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
      2'd1:    kat_ct = 128'hf5d3d58503b9699de785895a96fdbaaf;
      2'd2:    kat_ct = 128'h43b1cd7f598ece23881b00e3ed030688;
      default: kat_ct = 128'h7b0c785e27e8ad3f8223207104725dd4;
    endcase
  endfunction

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [127:0]     result;
  logic             forced_fail;
  logic             pass_fail;
  logic             last;
  logic             hit;
  logic             ok_next;

  assign last = (vec_idx == LAST);
  assign hit  = !forced_fail && (result == kat_ct(vec_idx));
  // pass_ok must be high during CHECK itself, so the last vector is also scored as it arrives.
  assign ok_next = last && !pass_fail && (aes_text_out == kat_ct(vec_idx));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      tmr         <= '0;
      result      <= '0;
      forced_fail <= 1'b0;
      pass_fail   <= 1'b0;
      aes_ld      <= 1'b0;
      aes_key     <= '0;
      aes_text_in <= '0;
      busy        <= 1'b0;
      vec_idx     <= 2'd0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      error       <= 1'b0;
      pass_ok     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      aes_ld  <= 1'b0;
      pass_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= GAP;
            busy      <= 1'b1;
            tmr       <= GAP_LD;
            vec_idx   <= 2'd0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            error     <= 1'b0;
            timeout   <= 1'b0;
            pass_fail <= 1'b0;
          end
        end
        GAP: begin
          if (tmr == '0) begin
            state       <= LOAD;
            aes_ld      <= 1'b1;
            aes_key     <= KAT_KEY;
            aes_text_in <= kat_pt(vec_idx);
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        LOAD: begin
          state <= WAIT;
          tmr   <= TO_LD;
        end
        WAIT: begin
          if (aes_done) begin
            state       <= CHECK;
            result      <= aes_text_out;
            forced_fail <= 1'b0;
            pass_ok     <= ok_next;
          end
`ifdef AES_KAT_TIMEOUT_EN
          else if (tmr == '0) begin
            state       <= CHECK;
            forced_fail <= 1'b1;
            timeout     <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
`endif
        end
        CHECK: begin
          if (hit) begin
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
          end else begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
            error     <= 1'b1;
            pass_fail <= 1'b1;
          end
          if (!last) begin
            state   <= GAP;
            tmr     <= GAP_LD;
            vec_idx <= vec_idx + 2'd1;
          end else if (loop) begin
            // Loop restart opens a fresh pass; its fail flag overrides this cycle's set.
            state     <= GAP;
            tmr       <= GAP_LD;
            vec_idx   <= 2'd0;
            pass_fail <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Bench for aes_kat_sequencer: a behavioural 12-cycle AES core model plus a load-event scoreboard.
module tb_aes_kat_sequencer;

  localparam int GAP  = 100;
  localparam int LAT  = 12;
  localparam int TO   = 50;
  localparam int STEP = LAT + GAP + 2;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct {
    int           c;
    logic [127:0] pt;
    logic [127:0] key;
  } ld_t;

  function automatic logic [127:0] kat_pt(input int i);
    case (i)
      0:       return 128'h6bc1bee22e409f96e93d7e117393172a;
      1:       return 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      2:       return 128'h30c81c46a35ce411e5fbc1191a0a52ef;
      default: return 128'hf69f2445df4f9b17ad2b417be66c3710;
    endcase
  endfunction

  function automatic logic [127:0] kat_ct(input int i);
    case (i)
      0:       return 128'h3ad77bb40d7a3660a89ecaf32466ef97;
      1:       return 128'hf5d3d58503b9699de785895a96fdbaaf;
      2:       return 128'h43b1cd7f598ece23881b00e3ed030688;
      default: return 128'h7b0c785e27e8ad3f8223207104725dd4;
    endcase
  endfunction

  function automatic logic [127:0] model_ct(input logic [127:0] pt);
    for (int i = 0; i < 4; i++) if (pt == kat_pt(i)) return kat_ct(i);
    return '0;
  endfunction

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic start = 1'b0, loop = 1'b0, start2 = 1'b0, loop2 = 1'b0;
  logic inj_done = 1'b0;
  logic [127:0] inj_text = '0;

  // main DUT
  logic         aes_ld, aes_done, busy, error, pass_ok, timeout;
  logic [127:0] aes_key, aes_text_in, aes_text_out;
  logic [1:0]   vec_idx;
  logic [15:0]  pass_cnt, fail_cnt;
  // saturation DUT
  logic         aes_ld2, aes_done2, busy2, error2, pass_ok2, timeout2;
  logic [127:0] aes_key2, aes_text_in2, aes_text_out2;
  logic [1:0]   vec_idx2;
  logic [1:0]   pass_cnt2, fail_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  ld_t exp_q[$];
  ld_t obs_q[$];
  int  ok_q[$];

  bit           core_en = 1'b0;
  int           corrupt_vec = -1;
  logic         m_done = 1'b0, m_done2 = 1'b0;
  logic [127:0] m_text = '0, m_text2 = '0, m_pt = '0, m_pt2 = '0;
  int           m_cnt = 0, m_cnt2 = 0;

  assign aes_done      = m_done | inj_done;
  assign aes_text_out  = inj_done ? inj_text : m_text;
  assign aes_done2     = m_done2;
  assign aes_text_out2 = m_text2;

  aes_kat_sequencer #(.NUM_VEC(4), .GAP_CYCLES(GAP), .CNT_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .loop(loop),
    .aes_ld(aes_ld), .aes_key(aes_key), .aes_text_in(aes_text_in),
    .aes_done(aes_done), .aes_text_out(aes_text_out), .busy(busy), .vec_idx(vec_idx),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .error(error), .pass_ok(pass_ok), .timeout(timeout)
  );

  aes_kat_sequencer #(.NUM_VEC(2), .GAP_CYCLES(3), .CNT_W(2), .TIMEOUT_CYCLES(TO)) dut_sat (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start2), .loop(loop2),
    .aes_ld(aes_ld2), .aes_key(aes_key2), .aes_text_in(aes_text_in2),
    .aes_done(aes_done2), .aes_text_out(aes_text_out2), .busy(busy2), .vec_idx(vec_idx2),
    .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .error(error2), .pass_ok(pass_ok2), .timeout(timeout2)
  );

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Core models: done is raised at the negedge LAT cycles after the load cycle, so it is seen in that cycle.
  always @(negedge sys_clk) begin
    m_done = 1'b0;
    if (core_en && aes_ld) begin
      m_cnt = LAT;
      m_pt  = aes_text_in;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_text = model_ct(m_pt);
        if (corrupt_vec >= 0 && m_pt == kat_pt(corrupt_vec)) m_text[0] = ~m_text[0];
      end
    end
  end

  always @(negedge sys_clk) begin
    m_done2 = 1'b0;
    if (core_en && aes_ld2) begin
      m_cnt2 = LAT;
      m_pt2  = aes_text_in2;
    end else if (m_cnt2 > 0) begin
      m_cnt2--;
      if (m_cnt2 == 0) begin
        m_done2 = 1'b1;
        m_text2 = model_ct(m_pt2);
      end
    end
  end

  task automatic do_start(output int sc);
    @(negedge sys_clk);
    start = 1'b1;
    sc = cyc;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  // Records loads and pass_ok pulses of the main DUT until busy drops or the budget runs out.
  task automatic run_pass(input int budget, input int drop_loop_at, output int n_ld, output int n_ok,
                          output int idle_c, output bit expired);
    n_ld = 0; n_ok = 0; idle_c = -1; expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      ld_t o;
      @(negedge sys_clk);
      if (aes_ld) begin
        o.c = cyc; o.pt = aes_text_in; o.key = aes_key;
        obs_q.push_back(o);
        n_ld++;
        if (n_ld == drop_loop_at) loop = 1'b0;
      end
      if (pass_ok) begin
        n_ok++;
        ok_q.push_back(cyc);
      end
      if (!busy) begin
        idle_c = cyc; expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic push_exp(input int sc, input int n, input int step);
    for (int k = 0; k < n; k++) begin
      ld_t e;
      e.c = sc + GAP + 1 + k * step; e.pt = kat_pt(k % 4); e.key = KEY;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; start = 1'b1; start2 = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (aes_ld !== 1'b0) begin n_fail++; $display("FAIL reset_ld: got %b want 0", aes_ld); end
    n_checks++; if (vec_idx !== 2'd0) begin n_fail++; $display("FAIL reset_vec_idx: got %0d want 0", vec_idx); end
    n_checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
    n_checks++; if ({error, pass_ok, timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {error, pass_ok, timeout}); end
    n_checks++; if (aes_text_in !== '0 || aes_key !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h want 0", aes_text_in, aes_key); end
    n_checks++; if (busy2 !== 1'b0 || pass_cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_sat: got %b %0d want 0 0", busy2, pass_cnt2); end
    start = 1'b0; start2 = 1'b0;
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_single_pass();
    int sc, n_ld, n_ok, idle_c, last_ld;
    bit expired;
    core_en = 1'b1; corrupt_vec = -1; loop = 1'b0;
    exp_q.delete(); obs_q.delete(); ok_q.delete();
    do_start(sc);
    push_exp(sc, 4, STEP);
    last_ld = sc + GAP + 1 + 3 * STEP;
    run_pass(1000, 0, n_ld, n_ok, idle_c, expired);
    n_checks++; if (expired) begin n_fail++; $display("FAIL single_budget: busy still %b want 0", busy); end
    n_checks++; if (n_ld !== 4) begin n_fail++; $display("FAIL single_ld_count: got %0d want 4", n_ld); end
    while (exp_q.size() > 0) begin
      ld_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL single_ld_missing: got none want cycle %0d", e.c); end
      else begin
        o = obs_q.pop_front();
        if (o.c !== e.c || o.pt !== e.pt || o.key !== e.key) begin
          n_fail++; $display("FAIL single_ld: got c=%0d pt=%h key=%h want c=%0d pt=%h key=%h", o.c, o.pt, o.key, e.c, e.pt, e.key);
        end
      end
    end
    n_checks++; if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0) begin n_fail++; $display("FAIL single_cnt: got %0d/%0d want 4/0", pass_cnt, fail_cnt); end
    n_checks++; if (error !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL single_flags: got err=%b to=%b want 0 0", error, timeout); end
    n_checks++; if (n_ok !== 1) begin n_fail++; $display("FAIL single_ok_count: got %0d want 1", n_ok); end
    n_checks++; if (ok_q.size() > 0 && ok_q[0] !== last_ld + LAT + 1) begin n_fail++; $display("FAIL single_ok_cycle: got %0d want %0d", ok_q[0], last_ld + LAT + 1); end
    n_checks++; if (idle_c !== last_ld + LAT + 2) begin n_fail++; $display("FAIL single_busy_fall: got %0d want %0d", idle_c, last_ld + LAT + 2); end
  endtask

  task automatic test_mismatch();
    int sc, n_ld, n_ok, idle_c;
    bit expired;
    core_en = 1'b1; corrupt_vec = 2; loop = 1'b0;
    exp_q.delete(); obs_q.delete(); ok_q.delete();
    do_start(sc);
    push_exp(sc, 4, STEP);
    run_pass(1000, 0, n_ld, n_ok, idle_c, expired);
    n_checks++; if (expired || n_ld !== 4) begin n_fail++; $display("FAIL mismatch_run: got ld=%0d expired=%b want 4 0", n_ld, expired); end
    while (exp_q.size() > 0) begin
      ld_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL mismatch_ld_missing: got none want cycle %0d", e.c); end
      else begin
        o = obs_q.pop_front();
        if (o.c !== e.c || o.pt !== e.pt) begin n_fail++; $display("FAIL mismatch_ld: got c=%0d pt=%h want c=%0d pt=%h", o.c, o.pt, e.c, e.pt); end
      end
    end
    n_checks++; if (pass_cnt !== 16'd3 || fail_cnt !== 16'd1) begin n_fail++; $display("FAIL mismatch_cnt: got %0d/%0d want 3/1", pass_cnt, fail_cnt); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL mismatch_error: got %b want 1", error); end
    n_checks++; if (n_ok !== 0) begin n_fail++; $display("FAIL mismatch_pass_ok: got %0d pulses want 0", n_ok); end
    corrupt_vec = -1;
  endtask

  task automatic test_loop();
    int sc, n_ld, n_ok, idle_c, last_ld;
    bit expired;
    core_en = 1'b1; corrupt_vec = -1; loop = 1'b1;
    exp_q.delete(); obs_q.delete(); ok_q.delete();
    do_start(sc);
    push_exp(sc, 12, STEP);
    last_ld = sc + GAP + 1 + 11 * STEP;
    run_pass(3000, 9, n_ld, n_ok, idle_c, expired);
    n_checks++; if (expired || n_ld !== 12) begin n_fail++; $display("FAIL loop_run: got ld=%0d expired=%b want 12 0", n_ld, expired); end
    while (exp_q.size() > 0) begin
      ld_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL loop_ld_missing: got none want cycle %0d", e.c); end
      else begin
        o = obs_q.pop_front();
        if (o.c !== e.c || o.pt !== e.pt) begin n_fail++; $display("FAIL loop_ld: got c=%0d pt=%h want c=%0d pt=%h", o.c, o.pt, e.c, e.pt); end
      end
    end
    n_checks++; if (pass_cnt !== 16'd12 || fail_cnt !== 16'd0 || error !== 1'b0) begin n_fail++; $display("FAIL loop_cnt: got %0d/%0d err=%b want 12/0 err=0", pass_cnt, fail_cnt, error); end
    n_checks++; if (n_ok !== 3) begin n_fail++; $display("FAIL loop_ok_count: got %0d want 3", n_ok); end
    for (int j = 0; j < 3 && j < ok_q.size(); j++) begin
      int want;
      want = sc + GAP + 1 + (4 * j + 3) * STEP + LAT + 1;
      n_checks++; if (ok_q[j] !== want) begin n_fail++; $display("FAIL loop_ok_cycle%0d: got %0d want %0d", j, ok_q[j], want); end
    end
    n_checks++; if (idle_c !== last_ld + LAT + 2) begin n_fail++; $display("FAIL loop_busy_fall: got %0d want %0d", idle_c, last_ld + LAT + 2); end
  endtask

  task automatic test_reset_mid();
    int sc, n;
    bit found;
    core_en = 1'b1; loop = 1'b0; n = 0; found = 1'b0;
    do_start(sc);
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      if (aes_ld) begin
        n++;
        if (n == 2) begin found = 1'b1; break; end
      end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_second_load: got %0d loads want 2", n); end
    repeat (5) @(negedge sys_clk);
    n_checks++; if (pass_cnt !== 16'd1 || vec_idx !== 2'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got cnt=%0d idx=%0d busy=%b want 1 1 1", pass_cnt, vec_idx, busy); end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if ({aes_ld, busy, vec_idx, error, pass_ok, timeout} !== 7'd0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || aes_text_in !== '0 || aes_key !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got ld=%b busy=%b idx=%0d cnt=%0d/%0d flags=%b%b%b want all 0", aes_ld, busy, vec_idx, pass_cnt, fail_cnt, error, pass_ok, timeout);
    end
    sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);
    n_checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_done: got cnt=%0d/%0d busy=%b want 0/0 0", pass_cnt, fail_cnt, busy); end
  endtask

  task automatic test_spurious_done();
    int sc;
    bit found;
    core_en = 1'b0; loop = 1'b0; found = 1'b0;
    do_start(sc);
    repeat (40) @(negedge sys_clk);
    inj_text = kat_ct(0); inj_done = 1'b1;
    @(negedge sys_clk);
    inj_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (aes_ld) begin found = 1'b1; break; end
    end
    inj_done = 1'b1;   // coincides with the LOAD cycle
    @(negedge sys_clk);
    inj_done = 1'b0;
    repeat (4) @(negedge sys_clk);
    n_checks++; if (!found || busy !== 1'b1 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || vec_idx !== 2'd0) begin
      n_fail++; $display("FAIL spurious_ignored: got ld=%b busy=%b cnt=%0d/%0d idx=%0d want 1 1 0/0 0", found, busy, pass_cnt, fail_cnt, vec_idx);
    end
    inj_done = 1'b1;
    @(negedge sys_clk);
    inj_done = 1'b0;
    @(negedge sys_clk);
    n_checks++; if (pass_cnt !== 16'd1 || vec_idx !== 2'd1) begin n_fail++; $display("FAIL spurious_wait_done: got cnt=%0d idx=%0d want 1 1", pass_cnt, vec_idx); end
    do_start(sc);   // busy, so it must not clear the counters
    @(negedge sys_clk);
    n_checks++; if (pass_cnt !== 16'd1 || vec_idx !== 2'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL start_while_busy: got cnt=%0d idx=%0d busy=%b want 1 1 1", pass_cnt, vec_idx, busy); end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_watchdog();
    int sc;
`ifdef AES_KAT_TIMEOUT_EN
    int n_ld, n_ok, idle_c;
    bit expired;
    core_en = 1'b0; loop = 1'b0;
    exp_q.delete(); obs_q.delete(); ok_q.delete();
    do_start(sc);
    push_exp(sc, 4, TO + GAP + 2);
    run_pass(1500, 0, n_ld, n_ok, idle_c, expired);
    n_checks++; if (expired || n_ld !== 4) begin n_fail++; $display("FAIL wdog_run: got ld=%0d expired=%b want 4 0", n_ld, expired); end
    while (exp_q.size() > 0) begin
      ld_t e, o;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL wdog_ld_missing: got none want cycle %0d", e.c); end
      else begin
        o = obs_q.pop_front();
        if (o.c !== e.c || o.pt !== e.pt) begin n_fail++; $display("FAIL wdog_ld: got c=%0d pt=%h want c=%0d pt=%h", o.c, o.pt, e.c, e.pt); end
      end
    end
    n_checks++; if (fail_cnt !== 16'd4 || pass_cnt !== 16'd0) begin n_fail++; $display("FAIL wdog_cnt: got %0d/%0d want 0/4", pass_cnt, fail_cnt); end
    n_checks++; if (timeout !== 1'b1 || error !== 1'b1 || n_ok !== 0) begin n_fail++; $display("FAIL wdog_flags: got to=%b err=%b ok=%0d want 1 1 0", timeout, error, n_ok); end
`else
    core_en = 1'b0; loop = 1'b0;
    do_start(sc);
    repeat (400) @(negedge sys_clk);
    n_checks++; if (busy !== 1'b1 || vec_idx !== 2'd0 || fail_cnt !== 16'd0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL no_wdog_wait: got busy=%b idx=%0d fail=%0d to=%b want 1 0 0 0", busy, vec_idx, fail_cnt, timeout);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
`endif
  endtask

  task automatic test_saturation();
    int n, n_ok, bad_pt;
    bit wrapped, done;
    logic [1:0] prev;
    core_en = 1'b1; loop2 = 1'b1;
    n = 0; n_ok = 0; bad_pt = 0; wrapped = 1'b0; done = 1'b0; prev = 2'd0;
    @(negedge sys_clk); start2 = 1'b1;
    @(negedge sys_clk); start2 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge sys_clk);
      if (aes_ld2) begin
        if (aes_text_in2 !== kat_pt(n % 2) || vec_idx2 > 2'd1) bad_pt++;
        n++;
        if (n == 7) loop2 = 1'b0;
      end
      if (pass_ok2) n_ok++;
      if (pass_cnt2 < prev) wrapped = 1'b1;
      prev = pass_cnt2;
      if (!busy2) begin done = 1'b1; break; end
    end
    n_checks++; if (!done || n !== 8) begin n_fail++; $display("FAIL sat_run: got ld=%0d done=%b want 8 1", n, done); end
    n_checks++; if (bad_pt !== 0) begin n_fail++; $display("FAIL sat_vectors: got %0d bad loads want 0", bad_pt); end
    n_checks++; if (pass_cnt2 !== 2'd3 || wrapped) begin n_fail++; $display("FAIL sat_pass_cnt: got %0d wrapped=%b want 3 0", pass_cnt2, wrapped); end
    n_checks++; if (fail_cnt2 !== 2'd0 || error2 !== 1'b0 || timeout2 !== 1'b0) begin n_fail++; $display("FAIL sat_flags: got %0d %b %b want 0 0 0", fail_cnt2, error2, timeout2); end
    n_checks++; if (n_ok !== 4) begin n_fail++; $display("FAIL sat_pass_ok: got %0d want 4", n_ok); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_mismatch();
    test_loop();
    test_reset_mid();
    test_spurious_done();
    test_watchdog();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "bench timed out");
  end

endmodule
